mips_inst_encoder: RTL and testbench



---
 rtl/mips_isa_pkg.sv | 89 ++++++++
 rtl/mips_inst_pack.sv | 48 ++++
 rtl/mips_inst_encoder.sv | 169 ++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared MIPS ISA definitions for the instruction encoder.
//   - op_e        : abstract operation enum (values 22..31 are illegal)
//   - OPC_*/FUNCT_*: opcode and funct map (same map the control decoder uses)
//   - enc_state_e : encoder FSM states
//   - inst_desc_t : instruction descriptor payload
//   - r_word/i_word/j_word : field packers for the three instruction formats
package mips_isa_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned TGT_W   = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_ADDI, OP_AND,  OP_ANDI, OP_BEQ, OP_BNE, OP_J,    OP_JAL,
    OP_JR,   OP_LUI,  OP_LW,   OP_OR,  OP_ORI, OP_SLL,  OP_SRL,
    OP_SW,   OP_SUB,  OP_XOR,  OP_XORI, OP_SRA, OP_SLT, OP_SLTI
  } op_e;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
  localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OPC_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OPC_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA = 6'h03;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } enc_state_e;

  // op is kept as raw bits so illegal encodings can be carried
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } inst_desc_t;

  function automatic logic [WORD_W-1:0] r_word(input logic [REG_W-1:0]   rs,
                                                input logic [REG_W-1:0]   rt,
                                                input logic [REG_W-1:0]   rd,
                                                input logic [REG_W-1:0]   shamt,
                                                input logic [FUNCT_W-1:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [WORD_W-1:0] i_word(input logic [OPC_W-1:0] opc,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [IMM_W-1:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [WORD_W-1:0] j_word(input logic [OPC_W-1:0] opc,
                                                input logic [TGT_W-1:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/mips_inst_pack.sv
// mips_inst_pack: combinational descriptor -> 32-bit MIPS word.
//   desc    in   instruction descriptor (op + fields)
//   word    out  encoded instruction (0 when illegal)
//   illegal out  op is outside the defined enum range
// Fields that the format forces to zero are dropped here, not masked upstream.
module mips_inst_pack
  import mips_isa_pkg::*;
(
  input  inst_desc_t          desc,
  output logic [WORD_W-1:0]   word,
  output logic                illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (desc.op)
      // plain R-type ALU ops: shamt forced to zero
      OP_ADD:  word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_ADD);
      OP_AND:  word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_AND);
      OP_OR:   word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_OR);
      OP_SUB:  word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_SUB);
      OP_XOR:  word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_XOR);
      OP_SLT:  word = r_word(desc.rs, desc.rt, desc.rd, ZERO_REG, FUNCT_SLT);
      // shifts: rs forced to zero, shamt kept
      OP_SLL:  word = r_word(ZERO_REG, desc.rt, desc.rd, desc.shamt, FUNCT_SLL);
      OP_SRL:  word = r_word(ZERO_REG, desc.rt, desc.rd, desc.shamt, FUNCT_SRL);
      OP_SRA:  word = r_word(ZERO_REG, desc.rt, desc.rd, desc.shamt, FUNCT_SRA);
      // JR only uses rs
      OP_JR:   word = r_word(desc.rs, ZERO_REG, ZERO_REG, ZERO_REG, FUNCT_JR);
      OP_ADDI: word = i_word(OPC_ADDI, desc.rs, desc.rt, desc.imm);
      OP_ANDI: word = i_word(OPC_ANDI, desc.rs, desc.rt, desc.imm);
      OP_BEQ:  word = i_word(OPC_BEQ,  desc.rs, desc.rt, desc.imm);
      OP_BNE:  word = i_word(OPC_BNE,  desc.rs, desc.rt, desc.imm);
      OP_LW:   word = i_word(OPC_LW,   desc.rs, desc.rt, desc.imm);
      OP_ORI:  word = i_word(OPC_ORI,  desc.rs, desc.rt, desc.imm);
      OP_SW:   word = i_word(OPC_SW,   desc.rs, desc.rt, desc.imm);
      OP_XORI: word = i_word(OPC_XORI, desc.rs, desc.rt, desc.imm);
      OP_SLTI: word = i_word(OPC_SLTI, desc.rs, desc.rt, desc.imm);
      // LUI has no source register
      OP_LUI:  word = i_word(OPC_LUI, ZERO_REG, desc.rt, desc.imm);
      OP_J:    word = j_word(OPC_J,   desc.target);
      OP_JAL:  word = j_word(OPC_JAL, desc.target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: program loader that encodes instruction descriptors and
// writes them to instruction memory at consecutive word addresses.
//   clk, rst           clock, synchronous active-high reset
//   start, finish      begin program at BASE_ADDR / end program
//   in_valid/in_ready  descriptor stream handshake
//   in_op..in_target   descriptor fields
//   imem_we/addr/wdata registered instruction-memory write port (1-cycle latency)
//   count              words written since start
//   busy/done/full     state is LOAD / DONE / FULL
//   err_illegal        sticky, an illegal op was accepted since start
// Optional: define MIPS_INST_ENC_CHECKSUM_EN to add output checksum, the XOR
// of every word written since start.
module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                finish,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TGT_W-1:0]    in_target,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                err_illegal
`ifdef MIPS_INST_ENC_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   checksum
`endif
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  // count value before the final slot is written
  localparam logic [CNT_W-1:0]  LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  enc_state_e          state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                we_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [WORD_W-1:0]   wdata_nxt;
  logic                err_nxt;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
  logic [WORD_W-1:0]   checksum_nxt;
`endif

  inst_desc_t          desc_c;
  logic [WORD_W-1:0]   word_c;
  logic                illegal_c;
  logic                xfer_c;
  logic                write_c;
  logic                last_write_c;
  logic                restart_c;

  assign desc_c = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                    shamt: in_shamt, imm: in_imm, target: in_target};

  mips_inst_pack u_pack (
    .desc    (desc_c),
    .word    (word_c),
    .illegal (illegal_c)
  );

  // Handshake depends only on registered state, never on in_valid
  assign in_ready     = (state == ST_LOAD) && !count[ADDR_W];
  assign xfer_c       = in_valid && in_ready;
  assign write_c      = xfer_c && !illegal_c;
  assign last_write_c = write_c && (count == LAST_CNT);
  assign restart_c    = (state != ST_LOAD) && start;

  assign busy = (state == ST_LOAD);
  assign done = (state == ST_DONE);
  assign full = (state == ST_FULL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; filling the last slot takes priority over finish
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (last_write_c)  state_nxt = ST_FULL;
        else if (finish)   state_nxt = ST_DONE;
      end
      default: begin
        if (start) state_nxt = ST_LOAD;
      end
    endcase
  end

  // Next values for the registered write port and program bookkeeping
  always_comb begin
    we_nxt    = 1'b0;
    addr_nxt  = imem_addr;
    wdata_nxt = imem_wdata;
    ptr_nxt   = ptr;
    count_nxt = count;
    err_nxt   = err_illegal;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
    checksum_nxt = checksum;
`endif
    if (restart_c) begin
      ptr_nxt   = BASE;
      count_nxt = '0;
      err_nxt   = 1'b0;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
      checksum_nxt = '0;
`endif
    end else if (xfer_c) begin
      if (illegal_c) begin
        err_nxt = 1'b1;
      end else begin
        we_nxt    = 1'b1;
        addr_nxt  = ptr;
        wdata_nxt = word_c;
        ptr_nxt   = ptr + ADDR_W'(1);
        count_nxt = count + CNT_W'(1);
`ifdef MIPS_INST_ENC_CHECKSUM_EN
        checksum_nxt = checksum ^ word_c;
`endif
      end
    end
  end

  // Output and datapath registers; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we     <= 1'b0;
      imem_addr   <= BASE;
      imem_wdata  <= '0;
      ptr         <= BASE;
      count       <= '0;
      err_illegal <= 1'b0;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      imem_we     <= we_nxt;
      imem_addr   <= addr_nxt;
      imem_wdata  <= wdata_nxt;
      ptr         <= ptr_nxt;
      count       <= count_nxt;
      err_illegal <= err_nxt;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
      checksum    <= checksum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb_mips_inst_encoder: self-checking bench for mips_inst_encoder.
// Instance a uses ADDR_W=8, instance b uses ADDR_W=2 for the full-memory case.
module tb_mips_inst_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        start_a, finish_a, valid_a, ready_a, we_a, busy_a, done_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;

  logic        start_b, finish_b, valid_b, ready_b, we_b, busy_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

`ifdef MIPS_INST_ENC_CHECKSUM_EN
  logic [31:0] csum_a, csum_b;
`endif

  mips_inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .finish(finish_a),
    .in_valid(valid_a), .in_ready(ready_a), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
    .full(full_a), .err_illegal(err_a)
`ifdef MIPS_INST_ENC_CHECKSUM_EN
    , .checksum(csum_a)
`endif
  );

  mips_inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .finish(finish_b),
    .in_valid(valid_b), .in_ready(ready_b), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
    .full(full_b), .err_illegal(err_b)
`ifdef MIPS_INST_ENC_CHECKSUM_EN
    , .checksum(csum_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference ISA tables indexed by op: format (0=R,1=I,2=J) and funct/opcode
  int unsigned KIND [22] = '{0,1,0,1,1,1,2,2,0,1,1,0,1,0,0,1,0,0,1,0,0,1};
  int unsigned CODE [22] = '{'h20,'h08,'h24,'h0C,'h04,'h05,'h02,'h03,'h08,'h0F,'h23,
                             'h25,'h0D,'h00,'h02,'h2B,'h22,'h26,'h0E,'h03,'h2A,'h0A};

  function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned rs,
                                             input int unsigned rt, input int unsigned rd,
                                             input int unsigned sh, input int unsigned imm,
                                             input int unsigned tgt, output bit ill);
    int unsigned w;
    int unsigned s_rs, s_rt, s_rd, s_sh;
    s_rs = rs; s_rt = rt; s_rd = rd; s_sh = sh;
    w = 0;
    ill = (op > 21);
    if (!ill) begin
      if (KIND[op] == 0) begin
        if (op == 13 || op == 14 || op == 19) s_rs = 0;
        else s_sh = 0;
        if (op == 8) begin s_rt = 0; s_rd = 0; end
        w = s_rs * 2097152 + s_rt * 65536 + s_rd * 2048 + s_sh * 64 + CODE[op];
      end else if (KIND[op] == 1) begin
        if (op == 9) s_rs = 0;
        w = CODE[op] * 67108864 + s_rs * 2097152 + s_rt * 65536 + imm;
      end else begin
        w = CODE[op] * 67108864 + tgt;
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh,
                          input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt;
  endtask

  task automatic rand_desc();
    set_desc(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 16'($urandom), 26'($urandom));
  endtask

  function automatic logic [31:0] ref_cur(output bit ill);
    return ref_encode(32'(in_op), 32'(in_rs), 32'(in_rt), 32'(in_rd), 32'(in_shamt),
                      32'(in_imm), 32'(in_target), ill);
  endfunction

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  int unsigned m_ptr, m_count;
  bit          m_err, ill, exp_we, v;
  logic [31:0] w, m_sum, exp_wdata;
  int unsigned exp_addr;

  initial begin
    vecs[0] = '{op:5'd0,  rs:5'd1,  rt:5'd2, rd:5'd3, sh:5'd7, imm:16'h0,    tgt:26'h0,  exp:32'h00221820};
    vecs[1] = '{op:5'd1,  rs:5'd0,  rt:5'd8, rd:5'd0, sh:5'd0, imm:16'h5,    tgt:26'h0,  exp:32'h20080005};
    vecs[2] = '{op:5'd6,  rs:5'd0,  rt:5'd0, rd:5'd0, sh:5'd0, imm:16'h0,    tgt:26'h10, exp:32'h08000010};
    vecs[3] = '{op:5'd13, rs:5'd5,  rt:5'd1, rd:5'd2, sh:5'd4, imm:16'h0,    tgt:26'h0,  exp:32'h00011100};
    vecs[4] = '{op:5'd10, rs:5'd29, rt:5'd4, rd:5'd0, sh:5'd0, imm:16'hFFFC, tgt:26'h0,  exp:32'h8FA4FFFC};

    rst = 1'b1;
    start_a = 0; finish_a = 0; valid_a = 0;
    start_b = 0; finish_b = 0; valid_b = 0;
    set_desc(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_we", 64'(we_a), 64'(0));
    check("rst_addr", 64'(addr_a), 64'(0));
    check("rst_count", 64'(count_a), 64'(0));
    check("rst_flags", 64'({busy_a, done_a, full_a, err_a, ready_a}), 64'(0));

    start_a = 1; step(); start_a = 0;
    check("start_busy", 64'(busy_a), 64'(1));
    check("start_ready", 64'(ready_a), 64'(1));
    check("start_count", 64'(count_a), 64'(0));

    // directed vectors, back-to-back
    for (int i = 0; i < 5; i++) begin
      set_desc(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      valid_a = 1;
      step();
      check("vec_we", 64'(we_a), 64'(1));
      check("vec_addr", 64'(addr_a), 64'(i));
      check("vec_wdata", 64'(wdata_a), 64'(vecs[i].exp));
      check("vec_count", 64'(count_a), 64'(i + 1));
    end

    // illegal op accepted, no write
    set_desc(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    step(); valid_a = 0;
    check("ill_we", 64'(we_a), 64'(0));
    check("ill_err", 64'(err_a), 64'(1));
    check("ill_count", 64'(count_a), 64'(5));
    step();
    check("ill_sticky", 64'(err_a), 64'(1));

    finish_a = 1; step(); finish_a = 0;
    check("fin_done", 64'(done_a), 64'(1));
    check("fin_busy", 64'(busy_a), 64'(0));

    start_a = 1; step(); start_a = 0;
    check("restart_err", 64'(err_a), 64'(0));
    check("restart_count", 64'(count_a), 64'(0));
    check("restart_busy", 64'(busy_a), 64'(1));

    // randomized stream against reference model
    m_ptr = 0; m_count = 0; m_err = 0; m_sum = '0;
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 9) < 7);
      rand_desc();
      valid_a = v;
      check("rnd_ready", 64'(ready_a), 64'(m_count < 256));
      exp_we = 0;
      if (v && m_count < 256) begin
        w = ref_cur(ill);
        if (ill) m_err = 1;
        else begin
          exp_we = 1; exp_addr = m_ptr % 256; exp_wdata = w;
          m_ptr++; m_count++; m_sum ^= w;
        end
      end
      step();
      check("rnd_we", 64'(we_a), 64'(exp_we));
      if (exp_we) begin
        check("rnd_addr", 64'(addr_a), 64'(exp_addr));
        check("rnd_wdata", 64'(wdata_a), 64'(exp_wdata));
      end
      check("rnd_count", 64'(count_a), 64'(m_count));
      check("rnd_err", 64'(err_a), 64'(m_err));
    end
    valid_a = 0;
`ifdef MIPS_INST_ENC_CHECKSUM_EN
    check("rnd_checksum", 64'(csum_a), 64'(m_sum));
`endif

    // finish together with a transfer: write honoured, done at same time
    set_desc(5'd16, 5'd7, 5'd8, 5'd9, 5'd3, 16'h0, 26'h0);
    w = ref_cur(ill);
    valid_a = 1; finish_a = 1;
    step(); finish_a = 0;
    check("finx_we", 64'(we_a), 64'(1));
    check("finx_addr", 64'(addr_a), 64'(m_ptr % 256));
    check("finx_wdata", 64'(wdata_a), 64'(w));
    check("finx_done", 64'(done_a), 64'(1));
    check("finx_count", 64'(count_a), 64'(m_count + 1));

    // DONE ignores further descriptors
    check("done_ready", 64'(ready_a), 64'(0));
    step(); valid_a = 0;
    check("done_we", 64'(we_a), 64'(0));
    check("done_count", 64'(count_a), 64'(m_count + 1));

    // start and finish together from DONE: start wins
    start_a = 1; finish_a = 1; step(); start_a = 0; finish_a = 0;
    check("sf_busy", 64'(busy_a), 64'(1));
    check("sf_count", 64'(count_a), 64'(0));
`ifdef MIPS_INST_ENC_CHECKSUM_EN
    check("sf_checksum", 64'(csum_a), 64'(0));
`endif

    // reset during a transfer drops the write
    set_desc(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    valid_a = 1; rst = 1;
    step(); rst = 0; valid_a = 0;
    check("rstx_we", 64'(we_a), 64'(0));
    check("rstx_busy", 64'(busy_a), 64'(0));
    check("rstx_count", 64'(count_a), 64'(0));

    // ADDR_W=2 instance: fill all four slots
    start_b = 1; step(); start_b = 0;
    for (int i = 0; i < 4; i++) begin
      set_desc(5'd12, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 3 + 1), 26'd0);
      w = ref_cur(ill);
      valid_b = 1;
      step();
      check("full_we", 64'(we_b), 64'(1));
      check("full_addr", 64'(addr_b), 64'(i));
      check("full_wdata", 64'(wdata_b), 64'(w));
      check("full_count", 64'(count_b), 64'(i + 1));
      check("full_flag", 64'(full_b), 64'(i == 3));
    end
    check("full_ready", 64'(ready_b), 64'(0));
    step();
    check("full_5th_we", 64'(we_b), 64'(0));
    check("full_5th_count", 64'(count_b), 64'(4));
    valid_b = 0;
    start_b = 1; step(); start_b = 0;
    check("full_restart_busy", 64'(busy_b), 64'(1));
    check("full_restart_count", 64'(count_b), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
